// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Writeback stage feeding the register file write port. Results come from
//   two sources: the single-cycle ALU path and the multi-cycle load/store unit.
//
//   The ALU always wins the port. LSU results wait in a small in-order FIFO
//   and drain whenever the ALU leaves the port free. Writes to x0 are never
//   issued from either source. The rf_* outputs are registered, so there is
//   one cycle of latency from selection to the write.
//
//   Parameters
//     XLEN       data width of results and of rf_wd
//     LSU_DEPTH  LSU FIFO entries (power of two, >= 2)
//
//   Ports
//     clk, rst_n           clock, asynchronous active-low reset
//     alu_valid/rd/wd      ALU result; no backpressure
//     lsu_valid/rd/wd      LSU result offer
//     lsu_ready            LSU offer accepted when lsu_valid && lsu_ready
//     rf_we/rf_rd/rf_wd    registered register-file write port
//     lsu_count            current FIFO occupancy
//     wb_pending           (WB_SCOREBOARD_EN only) destinations with a write
//                          still outstanding in the FIFO or on the rf port
//
//   Build option
//     WB_SCOREBOARD_EN  adds the wb_pending output and its comparators.
module wb_arbiter #(
    parameter int XLEN      = 32,
    parameter int LSU_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         alu_valid,
    input  logic [4:0]                   alu_rd,
    input  logic [XLEN-1:0]              alu_wd,
    input  logic                         lsu_valid,
    output logic                         lsu_ready,
    input  logic [4:0]                   lsu_rd,
    input  logic [XLEN-1:0]              lsu_wd,
    output logic                         rf_we,
    output logic [4:0]                   rf_rd,
    output logic [XLEN-1:0]              rf_wd,
    output logic [$clog2(LSU_DEPTH):0]   lsu_count
`ifdef WB_SCOREBOARD_EN
    ,
    output logic [31:0]                  wb_pending
`endif
);

    localparam int PTR_W = $clog2(LSU_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LSU_DEPTH);

    logic [4:0]      fifo_rd [LSU_DEPTH];
    logic [XLEN-1:0] fifo_wd [LSU_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic alu_take;
    logic push;
    logic pop;

    // Handshake and arbitration decisions for this cycle. lsu_ready looks
    // only at the registered count, so a full FIFO refuses an offer even in
    // a cycle where it pops. An accepted offer to x0 completes but is
    // dropped. A pop only happens when the ALU does not claim the port, and
    // it reads the current head, so a push made this cycle cannot bypass.
    always_comb begin
        lsu_ready = (count != CNT_FULL);
        alu_take  = alu_valid && (alu_rd != 5'd0);
        push      = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
        pop       = !alu_take && (count != '0);
    end

    assign lsu_count = count;

    // FIFO storage carries no reset. Only the pointers and count decide
    // which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr] <= lsu_rd;
            fifo_wd[wr_ptr] <= lsu_wd;
        end
    end

    // FIFO pointers and occupancy. The pointers wrap naturally because the
    // depth is a power of two. A push and a pop in the same cycle leave the
    // count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Registered write port. On an idle cycle only the enable drops, and
    // address and data keep their last values. Reset clears everything, so
    // a write that was selected but not yet issued is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we <= 1'b0;
            rf_rd <= 5'd0;
            rf_wd <= '0;
        end else if (alu_take) begin
            rf_we <= 1'b1;
            rf_rd <= alu_rd;
            rf_wd <= alu_wd;
        end else if (pop) begin
            rf_we <= 1'b1;
            rf_rd <= fifo_rd[rd_ptr];
            rf_wd <= fifo_wd[rd_ptr];
        end else begin
            rf_we <= 1'b0;
        end
    end

`ifdef WB_SCOREBOARD_EN
    // Outstanding-destination map for decode. Slot i, counted from the
    // head, is valid when i < count. x0 is forced clear because it is never
    // written.
    always_comb begin
        wb_pending = 32'd0;
        for (int i = 0; i < LSU_DEPTH; i++) begin
            if (CNT_W'(i) < count) begin
                wb_pending[fifo_rd[rd_ptr + PTR_W'(i)]] = 1'b1;
            end
        end
        if (rf_we) begin
            wb_pending[rf_rd] = 1'b1;
        end
        wb_pending[0] = 1'b0;
    end
`endif

endmodule
